// File: rtl/bus_pkg.sv
// Shared types and status encodings for the 8085 bus cycle unit.
package bus_pkg;

    typedef enum logic [2:0] {
        CYC_OPF  = 3'd0,
        CYC_MRD  = 3'd1,
        CYC_MWR  = 3'd2,
        CYC_IORD = 3'd3,
        CYC_IOWR = 3'd4,
        CYC_INTA = 3'd5,
        CYC_HALT = 3'd6
    } cyc_type_t;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_T1     = 3'd1,
        S_T2     = 3'd2,
        S_TW     = 3'd3,
        S_T3     = 3'd4,
        S_HALTED = 3'd5,
        S_HOLD   = 3'd6
    } bus_state_t;

    localparam logic [1:0] ST_HALT  = 2'b00;
    localparam logic [1:0] ST_WRITE = 2'b01;
    localparam logic [1:0] ST_READ  = 2'b10;
    localparam logic [1:0] ST_FETCH = 2'b11;

    // Returns {s1, s0, io_m_n} for a cycle type.
    function automatic logic [2:0] cyc_status(input cyc_type_t t);
        case (t)
            CYC_OPF:  return {ST_FETCH, 1'b0};
            CYC_MRD:  return {ST_READ,  1'b0};
            CYC_MWR:  return {ST_WRITE, 1'b0};
            CYC_IORD: return {ST_READ,  1'b1};
            CYC_IOWR: return {ST_WRITE, 1'b1};
            CYC_INTA: return {ST_FETCH, 1'b1};
            default:  return {ST_HALT,  1'b0};
        endcase
    endfunction

    function automatic logic is_read(input cyc_type_t t);
        return (t == CYC_OPF) || (t == CYC_MRD) || (t == CYC_IORD);
    endfunction

    function automatic logic is_write(input cyc_type_t t);
        return (t == CYC_MWR) || (t == CYC_IOWR);
    endfunction

endpackage

// File: rtl/bus_wait_timer.sv
// Saturating count of wait-state cycles; o_timeout flags when MAX_WAIT is reached.
module bus_wait_timer #(
    parameter int MAX_WAIT = 15
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_timeout
);
    localparam int CW = $clog2(MAX_WAIT + 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != CW'(MAX_WAIT))) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_timeout = (r_cnt == CW'(MAX_WAIT));

endmodule

// File: rtl/bus_cycle_unit.sv
// 8085 machine-cycle sequencer (T1/T2/TW/T3) with HOLD/HLDA arbitration.
// Optional wait-state timeout enabled by defining WAIT_TIMEOUT_EN.
module bus_cycle_unit
    import bus_pkg::*;
#(
    parameter int MAX_WAIT = 15,
    parameter int AW       = 16
) (
    input  logic          phi1,
    input  logic          reset,
    input  logic          cyc_start,
    output logic          cyc_ack,
    input  logic [2:0]    cyc_type,
    input  logic [AW-1:0] cyc_addr,
    input  logic [7:0]    cyc_wdata,
    output logic          cyc_done,
    output logic [7:0]    rdata,
    output logic          busy,
    input  logic          ready,
    input  logic          hold,
    output logic          hlda,
    input  logic [7:0]    ad_in,
    output logic [7:0]    ad_out,
    output logic          ad_oe,
    output logic [7:0]    a_hi,
    output logic          ctl_oe,
    output logic          ale,
    output logic          rd_n,
    output logic          wr_n,
    output logic          inta_n,
    output logic          io_m_n,
    output logic          s1,
    output logic          s0,
    output logic          bus_err
);

    bus_state_t    r_state;
    cyc_type_t     r_type;
    logic [AW-1:0] r_addr;
    logic [7:0]    r_wdata;
    logic [7:0]    r_rdata;
    logic          r_done;
    logic          r_err;
    logic          r_timeout;
    logic          r_hold_halted;

    logic w_ack;
    logic w_in_cyc;
    logic w_strobe;
    logic w_timeout;

    assign w_ack    = cyc_start && ((r_state == S_IDLE) || (r_state == S_T3)) && !hold;
    assign w_in_cyc = (r_state == S_T1) || (r_state == S_T2) || (r_state == S_TW) || (r_state == S_T3);
    assign w_strobe = (r_state == S_T2) || (r_state == S_TW) || (r_state == S_T3);

`ifdef WAIT_TIMEOUT_EN
    logic w_tmr_timeout;

    bus_wait_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_timer (
        .i_clk     (phi1),
        .i_rst     (reset),
        .i_clr     (r_state == S_T1),
        .i_inc     (((r_state == S_T2) || (r_state == S_TW)) && !ready),
        .o_timeout (w_tmr_timeout)
    );

    assign w_timeout = w_tmr_timeout && (r_state == S_TW);
`else
    logic w_unused_cfg;
    assign w_unused_cfg = (MAX_WAIT != 0);
    assign w_timeout    = 1'b0;
`endif

    // Request fields are captured only on acceptance.
    always_ff @(posedge phi1) begin
        if (w_ack) begin
            r_type  <= cyc_type_t'(cyc_type);
            r_addr  <= cyc_addr;
            r_wdata <= cyc_wdata;
        end
    end

    always_ff @(posedge phi1) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
            r_timeout     <= 1'b0;
            r_hold_halted <= 1'b0;
            // A reset that aborts a bus cycle keeps the last read data.
            if (!w_in_cyc) begin
                r_rdata <= 8'h00;
            end
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (hold) begin
                        r_state       <= S_HOLD;
                        r_hold_halted <= 1'b0;
                    end else if (w_ack) begin
                        r_state <= S_T1;
                    end
                end
                S_T1: begin
                    r_timeout <= 1'b0;
                    if (r_type == CYC_HALT) begin
                        r_state <= S_HALTED;
                        r_done  <= 1'b1;
                    end else begin
                        r_state <= S_T2;
                    end
                end
                S_T2, S_TW: begin
                    if (ready) begin
                        r_state <= S_T3;
                    end else if (w_timeout) begin
                        r_state   <= S_T3;
                        r_timeout <= 1'b1;
                    end else begin
                        r_state <= S_TW;
                    end
                end
                S_T3: begin
                    if (is_read(r_type) || (r_type == CYC_INTA)) begin
                        r_rdata <= r_timeout ? 8'hFF : ad_in;
                    end
                    r_done <= 1'b1;
                    r_err  <= r_timeout;
                    if (w_ack) begin
                        r_state <= S_T1;
                    end else if (hold) begin
                        r_state       <= S_HOLD;
                        r_hold_halted <= 1'b0;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_HALTED: begin
                    if (hold) begin
                        r_state       <= S_HOLD;
                        r_hold_halted <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (!hold) begin
                        r_state <= r_hold_halted ? S_HALTED : S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Bus pins are a pure decode of the state and the latched request.
    always_comb begin
        cyc_ack  = w_ack;
        cyc_done = r_done;
        bus_err  = r_err;
        rdata    = r_rdata;
        busy     = (r_state != S_IDLE) && (r_state != S_HOLD);
        hlda     = (r_state == S_HOLD);
        ctl_oe   = (r_state != S_HOLD);
        ale      = (r_state == S_T1);
        a_hi     = r_addr[15:8];
        ad_out   = (r_state == S_T1) ? r_addr[7:0] : r_wdata;
        ad_oe    = (r_state == S_T1) || (w_strobe && is_write(r_type));
        rd_n     = !(w_strobe && is_read(r_type));
        wr_n     = !(w_strobe && is_write(r_type));
        inta_n   = !(w_strobe && (r_type == CYC_INTA));
        {s1, s0, io_m_n} = w_in_cyc ? cyc_status(r_type) : 3'b000;
    end

endmodule

// File: tb/tb_bus_cycle_unit.sv
// Directed self-checking bench for bus_cycle_unit.
module tb_bus_cycle_unit;
    import bus_pkg::*;

    logic        phi1;
    logic        reset;
    logic        cyc_start;
    logic        cyc_ack;
    logic [2:0]  cyc_type;
    logic [15:0] cyc_addr;
    logic [7:0]  cyc_wdata;
    logic        cyc_done;
    logic [7:0]  rdata;
    logic        busy;
    logic        ready;
    logic        hold;
    logic        hlda;
    logic [7:0]  ad_in;
    logic [7:0]  ad_out;
    logic        ad_oe;
    logic [7:0]  a_hi;
    logic        ctl_oe;
    logic        ale;
    logic        rd_n;
    logic        wr_n;
    logic        inta_n;
    logic        io_m_n;
    logic        s1;
    logic        s0;
    logic        bus_err;

    int n_tests = 0;
    int n_fail  = 0;

    bus_cycle_unit #(
        .MAX_WAIT (4),
        .AW       (16)
    ) dut (
        .phi1      (phi1),
        .reset     (reset),
        .cyc_start (cyc_start),
        .cyc_ack   (cyc_ack),
        .cyc_type  (cyc_type),
        .cyc_addr  (cyc_addr),
        .cyc_wdata (cyc_wdata),
        .cyc_done  (cyc_done),
        .rdata     (rdata),
        .busy      (busy),
        .ready     (ready),
        .hold      (hold),
        .hlda      (hlda),
        .ad_in     (ad_in),
        .ad_out    (ad_out),
        .ad_oe     (ad_oe),
        .a_hi      (a_hi),
        .ctl_oe    (ctl_oe),
        .ale       (ale),
        .rd_n      (rd_n),
        .wr_n      (wr_n),
        .inta_n    (inta_n),
        .io_m_n    (io_m_n),
        .s1        (s1),
        .s0        (s0),
        .bus_err   (bus_err)
    );

    initial begin
        phi1 = 1'b0;
        forever #5 phi1 = ~phi1;
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge phi1);
        #1;
    endtask

    // Presents a request at IDLE/T3, checks acceptance, returns sampled in T1.
    task automatic issue(input logic [2:0] t, input logic [15:0] a, input logic [7:0] d, input string tag);
        cyc_start = 1'b1;
        cyc_type  = t;
        cyc_addr  = a;
        cyc_wdata = d;
        #1;
        check({tag, "_ack"}, 16'(cyc_ack), 16'd1);
        tick();
        cyc_start = 1'b0;
    endtask

    // From T1, runs the cycle to its cyc_done, holding ready low for n_wait strobe cycles.
    task automatic run_cycle(input int n_wait, output int n_rd, output int n_wr, output int n_inta,
                             output int n_cyc, output logic [7:0] strb_ad, output logic done_err);
        int  left;
        bit  done;
        left     = n_wait;
        n_rd     = 0;
        n_wr     = 0;
        n_inta   = 0;
        n_cyc    = 1;
        strb_ad  = 8'h00;
        done_err = 1'b0;
        done     = 1'b0;
        for (int k = 0; k < 40 && !done; k++) begin
            if (!rd_n || !wr_n || !inta_n) begin
                ready = (left > 0) ? 1'b0 : 1'b1;
                if (left > 0) left--;
            end
            tick();
            n_cyc++;
            if (cyc_done) begin
                done     = 1'b1;
                done_err = bus_err;
            end else begin
                if (!rd_n)   n_rd++;
                if (!wr_n)   n_wr++;
                if (!inta_n) n_inta++;
                if (n_rd + n_wr + n_inta == 1) strb_ad = ad_out;
            end
        end
        ready = 1'b1;
        check("cycle_finished", 16'(done), 16'd1);
    endtask

    int         nrd, nwr, ninta, ncyc;
    logic [7:0] sad;
    logic       derr;

    initial begin
        reset     = 1'b1;
        cyc_start = 1'b0;
        cyc_type  = 3'd0;
        cyc_addr  = 16'h0000;
        cyc_wdata = 8'h00;
        ready     = 1'b1;
        hold      = 1'b0;
        ad_in     = 8'h00;
        tick();
        tick();
        check("rst_ale",    16'(ale),    16'd0);
        check("rst_ad_oe",  16'(ad_oe),  16'd0);
        check("rst_ctl_oe", 16'(ctl_oe), 16'd1);
        check("rst_strobes", 16'({rd_n, wr_n, inta_n}), 16'h7);
        check("rst_status", 16'({io_m_n, s1, s0}), 16'h0);
        check("rst_flags",  16'({hlda, cyc_done, bus_err, busy}), 16'h0);
        check("rst_rdata",  16'(rdata), 16'h00);
        reset = 1'b0;
        tick();

        // Memory read, no waits
        ad_in = 8'h3C;
        issue(CYC_MRD, 16'h2050, 8'h00, "mrd");
        check("mrd_t1_ale",  16'(ale), 16'd1);
        check("mrd_t1_ad",   16'({ad_oe, ad_out}), 16'h150);
        check("mrd_t1_ahi",  16'(a_hi), 16'h20);
        check("mrd_t1_stat", 16'({s1, s0, io_m_n}), 16'b100);
        run_cycle(0, nrd, nwr, ninta, ncyc, sad, derr);
        check("mrd_rd_cycles", 16'(nrd), 16'd2);
        check("mrd_done_cyc",  16'(ncyc), 16'd4);
        check("mrd_rdata",     16'(rdata), 16'h3C);
        check("mrd_err",       16'(derr), 16'd0);
        tick();
        check("mrd_done_pulse", 16'({cyc_done, rd_n}), 16'b01);

        // IO write with three wait states
        issue(CYC_IOWR, 16'h0081, 8'hA5, "iowr");
        check("iowr_t1_stat", 16'({s1, s0, io_m_n}), 16'b011);
        check("iowr_t1_ad",   16'({a_hi, ad_out}), 16'h0081);
        run_cycle(3, nrd, nwr, ninta, ncyc, sad, derr);
        check("iowr_wr_cycles", 16'(nwr), 16'd5);
        check("iowr_data",      16'(sad), 16'hA5);
        check("iowr_done_cyc",  16'(ncyc), 16'd7);
        check("iowr_rdata_keep", 16'(rdata), 16'h3C);

        // Back-to-back opcode fetches
        ad_in = 8'h11;
        issue(CYC_OPF, 16'h1000, 8'h00, "opf1");
        tick();
        tick();
        check("opf1_t3_rd", 16'(rd_n), 16'd0);
        cyc_start = 1'b1;
        cyc_type  = CYC_OPF;
        cyc_addr  = 16'h1001;
        #1;
        check("opf2_ack_t3", 16'(cyc_ack), 16'd1);
        tick();
        cyc_start = 1'b0;
        check("opf_b2b_done_ale", 16'({cyc_done, ale}), 16'b11);
        check("opf2_t1", 16'({s1, s0, ad_out}), 16'h301);
        check("opf1_rdata", 16'(rdata), 16'h11);
        ad_in = 8'h22;
        run_cycle(0, nrd, nwr, ninta, ncyc, sad, derr);
        check("opf2_done_cyc", 16'(ncyc), 16'd4);
        check("opf2_rdata", 16'(rdata), 16'h22);

        // Hold requested mid-cycle
        ad_in = 8'h5A;
        issue(CYC_MRD, 16'h3000, 8'h00, "hmrd");
        tick();
        hold = 1'b1;
        #1;
        check("hold_t2", 16'({hlda, rd_n}), 16'b00);
        tick();
        check("hold_t3", 16'({hlda, rd_n}), 16'b00);
        tick();
        check("hold_enter", 16'({cyc_done, hlda, ctl_oe, rd_n, ad_oe, busy}), 16'b110100);
        check("hold_rdata", 16'(rdata), 16'h5A);
        cyc_start = 1'b1;
        cyc_type  = CYC_MRD;
        #1;
        check("hold_no_ack", 16'(cyc_ack), 16'd0);
        tick();
        check("hold_stay", 16'({hlda, cyc_done}), 16'b10);
        hold      = 1'b0;
        cyc_start = 1'b0;
        tick();
        check("hold_exit", 16'({hlda, ctl_oe, busy}), 16'b010);

        // Reset during a wait state
        ad_in = 8'h77;
        ready = 1'b0;
        issue(CYC_MRD, 16'h4000, 8'h00, "rmrd");
        tick();
        tick();
        check("rst_tw", 16'({rd_n, busy}), 16'b01);
        reset = 1'b1;
        tick();
        check("rst_abort", 16'({rd_n, busy, cyc_done}), 16'b100);
        check("rst_abort_rdata", 16'(rdata), 16'h5A);
        reset = 1'b0;
        ready = 1'b1;
        tick();
        check("rst_after", 16'({cyc_done, busy}), 16'b00);
        check("rst_after_rdata", 16'(rdata), 16'h5A);

        // Interrupt acknowledge with one wait state
        ad_in = 8'hC7;
        issue(CYC_INTA, 16'h0038, 8'h00, "inta");
        check("inta_t1_stat", 16'({s1, s0, io_m_n}), 16'b111);
        run_cycle(1, nrd, nwr, ninta, ncyc, sad, derr);
        check("inta_strobes", 16'({4'(ninta), 4'(nrd)}), 16'h30);
        check("inta_done_cyc", 16'(ncyc), 16'd5);
        check("inta_rdata", 16'(rdata), 16'hC7);

        // Memory write
        issue(CYC_MWR, 16'h8001, 8'h3E, "mwr");
        check("mwr_t1_stat", 16'({s1, s0, io_m_n, a_hi}), 16'h280);
        run_cycle(0, nrd, nwr, ninta, ncyc, sad, derr);
        check("mwr_wr", 16'({4'(nwr), sad}), 16'h23E);

`ifdef WAIT_TIMEOUT_EN
        // Ready stuck low: forced completion after MAX_WAIT wait states
        ad_in = 8'h12;
        issue(CYC_MRD, 16'h5000, 8'h00, "tmo");
        run_cycle(100, nrd, nwr, ninta, ncyc, sad, derr);
        check("tmo_rd_cycles", 16'(nrd), 16'd6);
        check("tmo_done_cyc", 16'(ncyc), 16'd8);
        check("tmo_rdata", 16'(rdata), 16'hFF);
        check("tmo_bus_err", 16'(derr), 16'd1);
        tick();
        check("tmo_err_pulse", 16'(bus_err), 16'd0);
`endif

        // HALT: done after T1, then parked until reset; hold still serviced
        issue(CYC_HALT, 16'h0000, 8'h00, "halt");
        check("halt_t1", 16'({ale, s1, s0, io_m_n}), 16'b1000);
        tick();
        check("halt_enter", 16'({cyc_done, busy}), 16'b11);
        tick();
        check("halt_stay", 16'({cyc_done, busy}), 16'b01);
        cyc_start = 1'b1;
        cyc_type  = CYC_MRD;
        #1;
        check("halt_no_ack", 16'(cyc_ack), 16'd0);
        cyc_start = 1'b0;
        hold      = 1'b1;
        tick();
        check("halt_hold", 16'({hlda, ctl_oe}), 16'b10);
        hold = 1'b0;
        tick();
        check("halt_return", 16'({hlda, busy, cyc_done}), 16'b010);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("halt_reset", 16'(busy), 16'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
